// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared widths and the prefetch entry type for the CPU front end.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;
  localparam logic [ADDR_W-1:0] PC_INC = 64'h4;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with synchronous clear and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        din_i,
  input  logic                    pop_i,
  output logic [WIDTH-1:0]        dout_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW-1:0]    wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             w_do_push, w_do_pop;

  // Pointers wrap explicitly so non-power-of-2 depths work as well.
  always_comb begin
    w_do_push = push_i && (count_q != CW'(DEPTH));
    w_do_pop  = pop_i && (count_q != '0);
    rd_d      = rd_q;
    wr_d      = wr_q;
    count_d   = count_q;
    if (clr_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (w_do_push) wr_d = (wr_q == LAST) ? '0 : wr_q + AW'(1);
      if (w_do_pop)  rd_d = (rd_q == LAST) ? '0 : rd_q + AW'(1);
      count_d = count_q + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clr_i && w_do_push) mem_q[wr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch front end: PC, imem credit/squash, prefetch FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                MAX_OUT  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    imem_req_valid,
  input  logic                    imem_req_ready,
  output logic [ADDR_W-1:0]       imem_req_addr,
  input  logic                    imem_resp_valid,
  input  logic [INSTR_W-1:0]      imem_resp_instr,
  input  logic                    redirect,
  input  logic [ADDR_W-1:0]       redirect_addr,
  input  logic                    stall,
  output logic                    if_valid,
  output logic [INSTR_W-1:0]      if_instr,
  output logic [ADDR_W-1:0]       if_pcaddr,
  output logic [$clog2(DEPTH):0]  buf_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUT) + 1;
  localparam int SW = CW + OW;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [OW-1:0]     outstanding_q, outstanding_d;
  logic [OW-1:0]     squash_q, squash_d;

  logic              w_credit_ok;
  logic              w_req_fire;
  logic              w_squash_hit;
  logic              w_pf_push;
  logic              w_pf_pop;
  logic [ADDR_W-1:0] w_tag_pc;
  logic [OW-1:0]     w_tag_count;
  logic [CW-1:0]     w_buf_count;
  fetch_entry_t      w_pf_din;
  fetch_entry_t      w_pf_head;

  // Buffered plus in-flight never exceeds DEPTH, so every response has a slot.
  assign w_credit_ok    = (SW'(w_buf_count) + SW'(outstanding_q)) < SW'(DEPTH);
  assign imem_req_valid = !rst && !redirect && w_credit_ok && (outstanding_q < OW'(MAX_OUT));
  assign imem_req_addr  = fetch_pc_q;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_squash_hit = imem_resp_valid && (squash_q != '0);
  assign w_pf_push    = imem_resp_valid && !w_squash_hit && !redirect;
  assign w_pf_pop     = if_valid && !stall && !redirect;
  assign w_pf_din     = '{addr: w_tag_pc, instr: imem_resp_instr};

  assign if_valid  = (w_buf_count != '0);
  assign if_instr  = if_valid ? w_pf_head.instr : '0;
  assign if_pcaddr = if_valid ? w_pf_head.addr  : '0;
  assign buf_count = w_buf_count;

  always_comb begin
    outstanding_d = outstanding_q + OW'(w_req_fire) - OW'(imem_resp_valid);
    fetch_pc_d    = fetch_pc_q;
    squash_d      = squash_q;
    if (redirect) begin
      fetch_pc_d = redirect_addr;
      squash_d   = outstanding_d;
    end else begin
      if (w_req_fire)   fetch_pc_d = fetch_pc_q + PC_INC;
      if (w_squash_hit) squash_d   = squash_q - OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      squash_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      squash_q      <= squash_d;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_prefetch_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (redirect),
    .push_i  (w_pf_push),
    .din_i   (w_pf_din),
    .pop_i   (w_pf_pop),
    .dout_o  (w_pf_head),
    .count_o (w_buf_count)
  );

  // Holds the PC of each in-flight request; squashed responses still pop it.
  sync_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (1'b0),
    .push_i  (w_req_fire),
    .din_i   (fetch_pc_q),
    .pop_i   (imem_resp_valid),
    .dout_o  (w_tag_pc),
    .count_o (w_tag_count)
  );

  a_pf_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_pf_push && (w_buf_count == CW'(DEPTH))));
  a_tag_tracks_credit: assert property (@(posedge clk) disable iff (rst)
    w_tag_count == outstanding_q);
  a_resp_has_request: assert property (@(posedge clk) disable iff (rst)
    !(imem_resp_valid && (outstanding_q == '0)));

endmodule
`default_nettype wire
